// File: rtl/scroll_seg_scan.sv
// Multiplexed N_DIG-digit 7-segment driver with a rotating nibble buffer, all on clk.
// Define SEG_DEADTIME_EN to blank 'an' for the first DEAD_CYC cycles of every scan slot.
module scroll_seg_scan #(
    parameter int                 N_DIG        = 8,
    parameter int                 REFRESH_DIV  = 5000,
    parameter int                 SCROLL_DIV   = 50000000,
    parameter logic [4*N_DIG-1:0] INIT_PATTERN = 32'h68110002,
    parameter int                 DEAD_CYC     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               pause,
    input  logic               load,
    input  logic [4*N_DIG-1:0] load_data,
    output logic [N_DIG-1:0]   an,
    output logic [6:0]         seg,
    output logic               wrap
);

    localparam int IW = $clog2(N_DIG);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    localparam logic [IW-1:0]    DIG_LAST    = IW'(N_DIG - 1);
    localparam logic [RW-1:0]    REF_LAST    = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0]    SCROLL_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [RW-1:0]    DEAD_LIM    = RW'(DEAD_CYC);
    localparam logic [N_DIG-1:0] AN_ONE      = N_DIG'(1);

`ifdef SEG_DEADTIME_EN
    localparam bit DEAD_ON = 1'b1;
`else
    localparam bit DEAD_ON = 1'b0;
`endif

    logic [N_DIG-1:0][3:0] digits;
    logic [N_DIG-1:0][3:0] digits_rot;
    logic [IW-1:0]         scan_idx;
    logic [IW-1:0]         step_cnt;
    logic [RW-1:0]         refresh_cnt;
    logic [SW-1:0]         scroll_cnt;

    logic refresh_tick;
    logic scroll_run;
    logic step_tick;
    logic step_wrap;
    logic dead_blank;

    assign refresh_tick = (refresh_cnt == REF_LAST);
    assign scroll_run   = en && !pause;
    assign step_tick    = scroll_run && (scroll_cnt == SCROLL_LAST);
    assign step_wrap    = step_tick && (step_cnt == DIG_LAST);
    assign dead_blank   = DEAD_ON && (refresh_cnt < DEAD_LIM);

    // Left: position k takes k+1; right: position k takes k-1; both wrap at the ends.
    assign digits_rot = dir ? {digits[N_DIG-2:0], digits[N_DIG-1]}
                            : {digits[0], digits[N_DIG-1:1]};

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b0011111;
            4'hC:    return 7'b1001110;
            4'hD:    return 7'b0111101;
            4'hE:    return 7'b1001111;
            default: return 7'b0000000;
        endcase
    endfunction

    // NOTE: state is updated with non-blocking assignments so every right-hand side
    // sees pre-edge values; this is what gives an/seg their one-cycle lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the digit buffer is reset because INIT_PATTERN is its defined power-on contents.
            digits      <= INIT_PATTERN;
            scan_idx    <= '0;
            refresh_cnt <= '0;
            scroll_cnt  <= '0;
            step_cnt    <= '0;
            an          <= '0;
            seg         <= '0;
            wrap        <= 1'b0;
        end else begin
            if (refresh_tick) begin
                refresh_cnt <= '0;
                scan_idx    <= (scan_idx == DIG_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end

            // A load discards any step tick landing on the same cycle.
            if (load) begin
                digits     <= load_data;
                scroll_cnt <= '0;
                step_cnt   <= '0;
            end else if (scroll_run) begin
                if (step_tick) begin
                    scroll_cnt <= '0;
                    digits     <= digits_rot;
                    step_cnt   <= step_wrap ? '0 : step_cnt + IW'(1);
                end else begin
                    scroll_cnt <= scroll_cnt + SW'(1);
                end
            end

            wrap <= step_wrap && !load;
            an   <= (en && !dead_blank) ? (AN_ONE << scan_idx) : '0;
            seg  <= en ? seg_decode(digits[scan_idx]) : 7'b0000000;
        end
    end

endmodule

// File: tb/tb_scroll_seg_scan.sv
// Directed bench for scroll_seg_scan (4 digits, 4-cycle slots, 32-cycle scroll steps).
// Expected an/seg/wrap are queued before each edge and compared one edge later.
module tb_scroll_seg_scan;

    localparam int N_DIG = 4;
    localparam int RDIV  = 4;
    localparam int SDIV  = 32;

`ifdef SEG_DEADTIME_EN
    localparam bit DEAD_ON = 1'b1;
`else
    localparam bit DEAD_ON = 1'b0;
`endif
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        dir = 1'b0;
    logic        pause = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       wrap;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    logic [6:0] dec_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b0000000
    };

    scroll_seg_scan #(
        .N_DIG       (N_DIG),
        .REFRESH_DIV (RDIV),
        .SCROLL_DIV  (SDIV),
        .INIT_PATTERN(16'h6810),
        .DEAD_CYC    (DEAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .pause    (pause),
        .load     (load),
        .load_data(load_data),
        .an       (an),
        .seg      (seg),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // exp_buf is the buffer content expected before each edge; wrap_at is the
    // 1-based edge within this run after which wrap must be high (0 = never).
    task automatic run(input int n, input logic [15:0] exp_buf, input int wrap_at);
        for (int i = 1; i <= n; i++) begin
            exp_t e;
            exp_t got;
            int   slot;
            slot   = (cyc / RDIV) % N_DIG;
            e.an   = en ? 4'(1 << slot) : 4'd0;
            if (DEAD_ON && ((cyc % RDIV) < DEAD))
                e.an = 4'd0;
            e.seg  = en ? dec_tab[exp_buf[slot*4 +: 4]] : 7'd0;
            e.wrap = (i == wrap_at);
            e.cyc  = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            cyc++;
            got = sb.pop_front();
            check($sformatf("an@%0d", got.cyc), 32'(an), 32'(got.an));
            check($sformatf("seg@%0d", got.cyc), 32'(seg), 32'(got.seg));
            check($sformatf("wrap@%0d", got.cyc), 32'(wrap), 32'(got.wrap));
        end
    endtask

    initial begin
        #3;
        check("rst_an", 32'(an), 32'd0);
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        #9;
        rst = 1'b0;
        cyc = 0;

        // Paused: plain scan of the reset pattern.
        run(16, 16'h6810, 0);

        // Left scroll through a full rotation; wrap after the fourth step.
        pause = 1'b0;
        run(SDIV, 16'h6810, 0);
        run(SDIV, 16'h0681, 0);
        run(SDIV, 16'h1068, 0);
        run(SDIV, 16'h8106, SDIV);

        // One right step, then a load on the next step-tick cycle.
        dir = 1'b1;
        run(SDIV, 16'h6810, 0);
        run(SDIV - 1, 16'h8106, 0);
        load      = 1'b1;
        load_data = 16'hF2F1;
        run(1, 16'h8106, 0);
        load      = 1'b0;
        load_data = 16'h0000;
        run(SDIV, 16'hF2F1, 0);

        // Disable mid-slot for 100 cycles; scroll counter must freeze.
        run(2, 16'h2F1F, 0);
        en = 1'b0;
        run(100, 16'h2F1F, 0);
        en = 1'b1;
        run(SDIV - 2, 16'h2F1F, 0);
        run(8, 16'hF1F2, 0);

        // Asynchronous reset mid-slot.
        #2;
        rst = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'd0);
        check("arst_seg", 32'(seg), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_an", 32'(an), 32'd0);
        check("arst_hold_seg", 32'(seg), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        cyc   = 0;
        pause = 1'b1;
        dir   = 1'b0;
        run(16, 16'h6810, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scroll_seg_scan.md
Name: scroll_seg_scan

Overview:
Parametrised multiplexed 7-segment driver with scrolling. It holds an N_DIG-digit nibble buffer and scans one digit per refresh slot. It rotates the buffer one position per scroll period, left or right, with pause and reload. It replaces the fixed 8-digit, derived-clock scanner; everything runs on the single system clock using enable ticks, with no generated clocks.

Parameters:
N_DIG, 8, number of digit positions (2..16)
REFRESH_DIV, 5000, clk cycles per digit scan slot (>=2)
SCROLL_DIV, 50000000, clk cycles per scroll step (>=2)
INIT_PATTERN, 32'h68110002, buffer reset value, 4*N_DIG bits, nibble k = position k
DEAD_CYC, 2, blanking cycles at slot start (used only with SEG_DEADTIME_EN; < REFRESH_DIV)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  1 = display and scrolling active
dir  in  1  0 = rotate left (position k takes k+1), 1 = rotate right (position k takes k-1)
pause  in  1  1 = freeze scroll counter and buffer; scanning continues
load  in  1  single-cycle pulse: copy load_data into buffer
load_data  in  4*N_DIG  new buffer contents, nibble k = position k
an  out  N_DIG  one-hot digit enable, an[k] drives position k, active-high
seg  out  7  segments {a,b,c,d,e,f,g}, active-high
wrap  out  1  one-cycle pulse when N_DIG scroll steps complete since last load/reset

Behaviour:
- Reset (async, any time): buffer=INIT_PATTERN; scan_idx=0; refresh_cnt=0; scroll_cnt=0; step_cnt=0; an=0; seg=0; wrap=0. Operation restarts from scan slot 0 on the first clk edge after rst is released.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. Refresh tick = cycle where refresh_cnt==REFRESH_DIV-1. On tick, scan_idx increments, wrapping N_DIG-1 -> 0.
- Scroll counter: counts 0..SCROLL_DIV-1 only when en=1 and pause=0; otherwise it holds. Step tick = cycle where scroll_cnt==SCROLL_DIV-1 with en=1 and pause=0. On step tick the buffer rotates one nibble in direction dir, with end wrap-around. dir is sampled on the tick cycle only.
- Load: a load=1 cycle writes load_data into the buffer and clears scroll_cnt and step_cnt, regardless of en/pause. Load has priority over a coincident step tick; that step is discarded.
- step_cnt increments on each step tick. When it reaches N_DIG it clears to 0 and wrap=1 on the following cycle. A coincident load suppresses wrap.
- Outputs are registered and lag by 1 cycle. an=onehot(scan_idx) and seg=decode(buffer nibble at scan_idx), both taken from the values present before the edge. A buffer change or scan_idx change at edge E appears on an/seg at edge E+1.
- en=0: an=0 and seg=0 on the next edge. Refresh continues; scroll is frozen.
- Decode: 0..9 standard digits (0 = 1111110, 1 = 0110000, 2 = 1101101, 6 = 1011111, 8 = 1111111). A..E = hex letters A, b, C, d, E. F = blank (0000000).
- Simultaneous refresh tick and step tick: both take effect on the same edge.

Optional Feature:
SEG_DEADTIME_EN defined: an is forced to 0 while refresh_cnt < DEAD_CYC (after the 1-cycle output lag) to suppress ghosting; seg is unaffected. Undefined: an is never blanked within a slot, and DEAD_CYC is ignored.

Test Plan:
- N_DIG=4, REFRESH_DIV=4, INIT_PATTERN=16'h6810, en=1, pause=1: release rst -> an cycles 0001,0010,0100,1000, 4 clks each. seg follows 1111110 (0), 0110000 (1), 1111111 (8), 1011111 (6). No buffer change.
- Same setup, SCROLL_DIV=32, dir=0, pause=0: after 32 clks the buffer becomes 16'h0681. wrap pulses once, 1 cycle, after 128 clks. The buffer then equals 16'h6810 again.
- dir=1 from 16'h6810: one step -> 16'h8106.
- load with load_data=16'hF2F1 on the same cycle as a step tick -> buffer=16'hF2F1 exactly (no rotation), scroll_cnt=0, and the next step occurs 32 clks later. Nibble F shows seg=0000000.
- en=0 mid-scan -> an=0 and seg=0 from the next edge; the buffer is unchanged over 100 clks. Re-enable -> scanning resumes at the current scan_idx.
- Assert rst asynchronously mid-slot -> an, seg and wrap are 0 immediately without a clock, and the buffer returns to INIT_PATTERN. With SEG_DEADTIME_EN and DEAD_CYC=2, an is 0 for the first 2 cycles of every slot.
